// File: rtl/handshake_tx_arb.sv
// Two-requester round-robin arbiter feeding a four-phase req/ack handshake
// toward a remote RX domain; ack is synchronised locally before use.
module handshake_tx_arb #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ch0_valid_i,
    input  logic [DW-1:0] ch0_data_i,
    output logic          ch0_ready_o,
    input  logic          ch1_valid_i,
    input  logic [DW-1:0] ch1_data_i,
    output logic          ch1_ready_o,
    output logic          req_o,
    output logic [DW-1:0] req_data_o,
    input  logic          ack_i,
    output logic          busy_o,
    output logic          grant_o,
    output logic          done_o
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_ACK   = 2'd1;
    localparam logic [1:0] WAIT_DEACK = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          ack_m_q, ack_s_q;
    logic          req_q, req_d;
    logic [DW-1:0] data_q, data_d;
    logic          rdy0_q, rdy0_d;
    logic          rdy1_q, rdy1_d;
    logic          grant_q, grant_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          win_c;

    // Two-flop synchroniser for the remote acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_m_q <= 1'b0;
            ack_s_q <= 1'b0;
        end else begin
            ack_m_q <= ack_i;
            ack_s_q <= ack_m_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            grant_q <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and registered-output decode; grant_q starts at 1 so ch0 wins first contention
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        grant_d = grant_q;
        done_d  = 1'b0;
        win_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ch0_valid_i || ch1_valid_i) begin
                    win_c   = (ch0_valid_i && ch1_valid_i) ? ~grant_q : ch1_valid_i;
                    state_d = WAIT_ACK;
                    req_d   = 1'b1;
                    data_d  = win_c ? ch1_data_i : ch0_data_i;
                    rdy0_d  = ~win_c;
                    rdy1_d  = win_c;
                    grant_d = win_c;
                end
            end
            WAIT_ACK: begin
                if (ack_s_q) begin
                    req_d   = 1'b0;
                    state_d = WAIT_DEACK;
                end
            end
            WAIT_DEACK: begin
                if (!ack_s_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign ch0_ready_o = rdy0_q;
    assign ch1_ready_o = rdy1_q;
    assign req_o       = req_q;
    assign req_data_o  = data_q;
    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_handshake_tx_arb.sv
// Bench for handshake_tx_arb: vector table plus multi-cycle sequences, with a
// remote RX model that pops expected {grant, data} from a scoreboard on each req rise.
module tb_handshake_tx_arb;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ch0_valid_i, ch1_valid_i;
    logic [DW-1:0] ch0_data_i, ch1_data_i;
    logic          ch0_ready_o, ch1_ready_o;
    logic          req_o;
    logic [DW-1:0] req_data_o;
    logic          ack_i;
    logic          busy_o, grant_o, done_o;

    logic          ack_model, ack_glitch;
    logic          rx_en;
    int            n_cmp, n_err, done_cnt;

    typedef struct {
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          exp_g;
        logic [DW-1:0] exp_d;
    } vec_t;

    typedef struct {
        logic          g;
        logic [DW-1:0] d;
    } exp_t;

    vec_t vecs[8];
    exp_t sbq[$];

    always #5 clk = ~clk;
    assign ack_i = ack_model | ack_glitch;

    handshake_tx_arb #(.DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch0_valid_i(ch0_valid_i),
        .ch0_data_i (ch0_data_i),
        .ch0_ready_o(ch0_ready_o),
        .ch1_valid_i(ch1_valid_i),
        .ch1_data_i (ch1_data_i),
        .ch1_ready_o(ch1_ready_o),
        .req_o      (req_o),
        .req_data_o (req_data_o),
        .ack_i      (ack_i),
        .busy_o     (busy_o),
        .grant_o    (grant_o),
        .done_o     (done_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Remote RX: acks 3 cycles after req rises, releases 3 cycles after req falls
    task automatic rx_model();
        int            cnt;
        logic          req_prev;
        logic [DW-1:0] cap;
        exp_t          e;
        cnt = 0;
        req_prev = 1'b0;
        cap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack_model = 1'b0;
                cnt = 0;
                req_prev = 1'b0;
                continue;
            end
            chk("ready_excl", 64'(ch0_ready_o & ch1_ready_o), 64'(0));
            if (ch0_ready_o || ch1_ready_o)
                chk("ready_after_grant", 64'(req_o && !req_prev), 64'(1));
            if (req_o && !req_prev) begin
                if (sbq.size() == 0) begin
                    timeout("rx_unexpected_req");
                end else begin
                    e = sbq.pop_front();
                    chk("rx_data", 64'(req_data_o), 64'(e.d));
                    chk("rx_grant", 64'(grant_o), 64'(e.g));
                end
                cap = req_data_o;
            end else if (req_o) begin
                chk("data_stable", 64'(req_data_o), 64'(cap));
            end
            if (done_o) done_cnt++;
            req_prev = req_o;
            if (rx_en && req_o && !ack_model) begin
                cnt++;
                if (cnt == 3) begin ack_model = 1'b1; cnt = 0; end
            end else if (rx_en && !req_o && ack_model) begin
                cnt++;
                if (cnt == 3) begin ack_model = 1'b0; cnt = 0; end
            end else begin
                cnt = 0;
            end
        end
    endtask

    task automatic wait_ready(output logic r0, output logic r1);
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ch0_ready_o || ch1_ready_o) begin
                r0 = ch0_ready_o;
                r1 = ch1_ready_o;
                return;
            end
        end
        timeout("ready_wait");
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_o) return;
        end
        timeout("done_wait");
    endtask

    task automatic run_vec(input vec_t e);
        logic r0, r1;
        int   snap;
        snap = done_cnt;
        sbq.push_back('{g: e.exp_g, d: e.exp_d});
        ch0_valid_i = e.v0;
        ch0_data_i  = e.d0;
        ch1_valid_i = e.v1;
        ch1_data_i  = e.d1;
        wait_ready(r0, r1);
        ch0_valid_i = 1'b0;
        ch1_valid_i = 1'b0;
        chk("ready0", 64'(r0), 64'(!e.exp_g));
        chk("ready1", 64'(r1), 64'(e.exp_g));
        chk("grant", 64'(grant_o), 64'(e.exp_g));
        wait_done();
        @(negedge clk);
        chk("done_once", 64'(done_cnt), 64'(snap + 1));
        chk("busy_after", 64'(busy_o), 64'(0));
    endtask

    initial begin
        logic r0, r1;
        logic stall_ok;
        int   snap;
        n_cmp = 0; n_err = 0; done_cnt = 0;
        rst_n = 1'b0;
        ack_model = 1'b0; ack_glitch = 1'b0; rx_en = 1'b1;
        ch0_valid_i = 1'b0; ch1_valid_i = 1'b0;
        ch0_data_i = '0; ch1_data_i = '0;

        vecs[0] = '{1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,  1'b0, 32'hA5A5A5A5};
        vecs[1] = '{1'b1, 32'h11,       1'b1, 32'h22, 1'b1, 32'h22};
        vecs[2] = '{1'b1, 32'h11,       1'b1, 32'h22, 1'b0, 32'h11};
        vecs[3] = '{1'b1, 32'h11,       1'b1, 32'h22, 1'b1, 32'h22};
        vecs[4] = '{1'b0, 32'h0,        1'b1, 32'h33, 1'b1, 32'h33};
        vecs[5] = '{1'b1, 32'h11,       1'b1, 32'h22, 1'b0, 32'h11};
        vecs[6] = '{1'b1, 32'h44,       1'b0, 32'h0,  1'b0, 32'h44};
        vecs[7] = '{1'b1, 32'h11,       1'b1, 32'h22, 1'b1, 32'h22};

        fork
            rx_model();
        join_none

        repeat (2) @(negedge clk);
        chk("rst_req", 64'(req_o), 64'(0));
        chk("rst_data", 64'(req_data_o), 64'(0));
        chk("rst_rdy", 64'({ch0_ready_o, ch1_ready_o}), 64'(0));
        chk("rst_done_busy", 64'({done_o, busy_o}), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Single transfer, then contention order 0,1,0,1, then mixed patterns
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Stalled ack: request must hold while valids churn
        rx_en = 1'b0;
        sbq.push_back('{g: 1'b0, d: 32'h77});
        ch0_valid_i = 1'b1; ch0_data_i = 32'h77;
        wait_ready(r0, r1);
        chk("stall_ready0", 64'(r0), 64'(1));
        stall_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ch0_valid_i = 1'($urandom);
            ch1_valid_i = 1'($urandom);
            ch0_data_i  = DW'($urandom);
            ch1_data_i  = DW'($urandom);
            @(negedge clk);
            if (!req_o || ch0_ready_o || ch1_ready_o || !busy_o) stall_ok = 1'b0;
        end
        chk("stall_hold", 64'(stall_ok), 64'(1));
        chk("stall_data", 64'(req_data_o), 64'(32'h77));
        ch0_valid_i = 1'b0; ch1_valid_i = 1'b0;

        // Ack glitch confined between edges must not be captured
        @(negedge clk);
        #1 ack_glitch = 1'b1;
        #2 ack_glitch = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_req", 64'(req_o), 64'(1));
        chk("glitch_busy", 64'(busy_o), 64'(1));
        rx_en = 1'b1;
        wait_done();
        @(negedge clk);
        chk("stall_end_busy", 64'(busy_o), 64'(0));

        // Reset while waiting for ack
        rx_en = 1'b0;
        sbq.push_back('{g: 1'b0, d: 32'h99});
        ch0_valid_i = 1'b1; ch0_data_i = 32'h99;
        wait_ready(r0, r1);
        ch0_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        snap = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_busy", 64'({req_o, busy_o}), 64'(0));
        chk("mid_rst_data", 64'(req_data_o), 64'(0));
        chk("mid_rst_rdy_done", 64'({ch0_ready_o, ch1_ready_o, done_o}), 64'(0));
        chk("mid_rst_grant", 64'(grant_o), 64'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_done", 64'(done_cnt), 64'(snap));
        rx_en = 1'b1;
        run_vec('{1'b0, 32'h0, 1'b1, 32'hBB, 1'b1, 32'hBB});

        // Back-to-back on ch1: next req rises the cycle after each done
        ch1_data_i = 32'h55;
        for (int i = 0; i < 3; i++) sbq.push_back('{g: 1'b1, d: 32'h55});
        ch1_valid_i = 1'b1;
        wait_ready(r0, r1);
        chk("b2b_first", 64'({r0, r1}), 64'(2'b01));
        for (int i = 0; i < 3; i++) begin
            wait_done();
            if (i < 2) begin
                @(negedge clk);
                chk("b2b_req", 64'(req_o), 64'(1));
                chk("b2b_ready", 64'({ch0_ready_o, ch1_ready_o}), 64'(2'b01));
                if (i == 1) ch1_valid_i = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_idle", 64'(busy_o), 64'(0));
        chk("sb_empty", 64'(sbq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
